// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its helpers.
//   clog2             : ceiling log2, never below 1, usable in constant expressions
//   state_t           : arbiter FSM state encoding (ST_IDLE / ST_LOCKED)
//   DEFAULT_MAX_BEATS : default watchdog limit on beats per grant
package fifo_arb_pkg;

    localparam int DEFAULT_MAX_BEATS = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Minimum of 1 so that a degenerate width never produces a zero-bit vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        in  N   request vector
//   last_grant in  IW  index granted most recently
//   any        out 1   at least one request is set
//   winner     out IW  first set request scanning last_grant+1, +2, ... mod N
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          any,
    output logic [IW-1:0] winner
);

    always_comb begin
        int  idx;
        logic found;
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Scanning offsets 1..N puts last_grant itself at the lowest priority.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter: shares one FIFO write port between NUM_REQ producers.
// A grant is held for a whole packet so packets never interleave in the FIFO;
// every written beat is tagged with its source ID and a last flag.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester beat valid
//   req_data      : packed beat data, requester i at [i*WIDTH +: WIDTH]
//   req_last      : per-requester last-beat flag
//   req_ready     : per-requester accept (one-hot or zero)
//   fifo_full     : FIFO full flag; no write is issued while it is high
//   fifo_wr_en    : FIFO write strobe
//   fifo_wr_data  : beat data of the granted requester
//   fifo_wr_id    : source ID of the beat
//   fifo_wr_last  : last flag of the beat (also forced by the watchdog)
//   grant_id      : current / most recent grant
//   busy          : high while a grant is locked
//   err_overrun   : sticky, set when a packet hits MAX_BEATS without last
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BEATS = DEFAULT_MAX_BEATS,
    localparam int ID_W      = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wr_data,
    output logic [ID_W-1:0]          fifo_wr_id,
    output logic                     fifo_wr_last,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     err_overrun
);

    localparam int CNT_W = clog2(MAX_BEATS + 1);

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  beat_cnt;

    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic              locked;
    logic              g_valid;
    logic              g_last;
    logic              transfer;
    logic              watchdog_fire;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_idx)
    );

    assign locked   = (state == ST_LOCKED);
    assign g_valid  = req_valid[grant_id];
    assign g_last   = req_last[grant_id];
    assign transfer = locked && !fifo_full && g_valid;

    // Beat MAX_BEATS of a packet with no last flag is closed off by force.
    assign watchdog_fire = transfer && !g_last && (beat_cnt == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        req_ready = '0;
        // Ready does not depend on valid: the locked requester may present
        // a beat at any time and it is taken immediately if the FIFO has room.
        if (locked && !fifo_full) req_ready[grant_id] = 1'b1;
    end

    assign fifo_wr_en   = transfer;
    assign fifo_wr_data = req_data[int'(grant_id)*WIDTH +: WIDTH];
    assign fifo_wr_id   = grant_id;
    assign fifo_wr_last = g_last | watchdog_fire;
    assign busy         = locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Idle beats (valid low) keep the lock indefinitely.
                    if (transfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (g_last || watchdog_fire) begin
                            state      <= ST_IDLE;
                            last_grant <= grant_id;
                        end
                        if (watchdog_fire) err_overrun <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_no_wr_when_full: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr_en && fifo_full));
    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

endmodule

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
- Shares the single write port of a team FIFO between NUM_REQ producers using round-robin arbitration.
- A grant is held for a whole packet (until the `last` beat) so packets are never interleaved in the FIFO.
- Each FIFO entry is tagged with the source ID and a last flag.
- Sits directly in front of the FIFO write side. It honours `fifo_full` and never issues a write while full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width per beat.
- MAX_BEATS, 16, maximum beats per grant before forced release (watchdog).
- ID_W, derived localparam = clog2(NUM_REQ), width of the source ID.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*WIDTH  packed beat data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NUM_REQ  per-requester last-beat-of-packet flag.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  WIDTH  data of the granted requester.
- fifo_wr_id  out  ID_W  source ID of the current beat.
- fifo_wr_last  out  1  last flag of the current beat.
- grant_id  out  ID_W  currently/most recently granted requester.
- busy  out  1  high while in LOCKED.
- err_overrun  out  1  sticky; set when the MAX_BEATS watchdog fires.

Behaviour:
State machine:
- Two states: IDLE and LOCKED. Registers: state, grant_id, last_grant, beat_cnt (clog2(MAX_BEATS+1) bits), err_overrun.

Reset:
- Synchronous, active-high. On reset: state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0, err_overrun=0.
- Resulting outputs: req_ready=0, fifo_wr_en=0, busy=0.
- A reset mid-packet drops the lock immediately. The partial packet stays in the FIFO; the arbiter does not clean it up.

IDLE:
- req_ready=0 and fifo_wr_en=0.
- If any req_valid is set, pick the first set bit scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
- On that cycle: register grant_id, clear beat_cnt, go to LOCKED.
- Arbitration latency is one cycle: data cannot be accepted in the same cycle a request first appears.

LOCKED:
- Let g = grant_id.
- req_ready[g] = !fifo_full; all other ready bits are 0.
- A transfer occurs when req_valid[g] && req_ready[g].
- Output path is combinational:
  - fifo_wr_en = transfer.
  - fifo_wr_data = req_data[g].
  - fifo_wr_id = g.
  - fifo_wr_last = req_last[g] OR watchdog_fire.
- On each transfer, beat_cnt increments.
- Transfer with req_last[g]=1: go to IDLE, last_grant<=g.
- Watchdog: a transfer where beat_cnt==MAX_BEATS-1 and req_last=0 still forces fifo_wr_last=1, sets err_overrun, goes to IDLE, and sets last_grant<=g.
- A requester that drops req_valid mid-packet keeps the lock. No timeout applies to idle beats.

Boundary conditions:
- fifo_full high: no write, no ready, state held. Deassertion resumes with zero extra latency.
- Only one requester active: it is re-granted after one IDLE cycle per packet.
- Wrap-around: the round-robin scan wraps from NUM_REQ-1 to 0.
- A requester whose valid appears while another is LOCKED waits; it is served in round-robin order at the next IDLE.
- Simultaneous valid on all requesters: the grant sequence is last_grant+1 … and is fair. No requester waits more than NUM_REQ-1 packets.

Invariants (assertions):
- fifo_wr_en is never high while fifo_full is high.
- req_ready is one-hot or zero.

Decomposition:
- Shared package fifo_arb_pkg:
  - clog2 function.
  - State enum constants ST_IDLE and ST_LOCKED.
  - Default MAX_BEATS.
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: req vector, last_grant. Outputs: any, winner index.
  - Natural to split out; reused by later read-side schedulers.

Test Plan:
- Single packet: NUM_REQ=4, req1 sends 3 beats 0xA1,0xA2,0xA3 (last on third). Required: busy rises one cycle after valid; 3 FIFO writes with id=1; fifo_wr_last only on 0xA3; IDLE after.
- Round robin: all four requesters hold 1-beat packets continuously from reset. Required grant order 0,1,2,3,0; each write is followed by one IDLE cycle.
- Back-pressure: fifo_full=1 for 5 cycles mid-packet of req2. Required: fifo_wr_en=0 and req_ready=0 throughout; no beat lost or duplicated; the packet completes after full drops.
- Watchdog: MAX_BEATS=4, req3 streams 6 beats without last. Required: 4th beat written with fifo_wr_last=1; err_overrun=1 and sticky; lock released; remaining beats form a new grant.
- Reset mid-packet: rst pulses after beat 2 of a 4-beat packet from req1. Required: next cycle busy=0, req_ready=0, err_overrun=0; the next grant goes to req0 if valid.
- Valid gap: the granted requester drops valid for 3 cycles mid-packet while others request. Required: no grant switch; no writes during the gap; the packet resumes.
